// File: rtl/icache_dm_ro_if.sv
// icache_dm_ro_if: fetch-side request/response and memory refill signals of the instruction cache.
// master = fetch stage plus memory model, slave = cache.
interface icache_dm_ro_if;
    logic         proc_ren;
    logic         proc_wen;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );

    modport slave (
        input  proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_dm_ro.sv
// icache_dm_ro: read-only direct-mapped instruction cache, 128-bit lines, same-cycle hits.
// Define ICACHE_PERF_CNT_EN to add the perf_hits/perf_misses counters.
module icache_dm_ro #(
    parameter int INDEX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    icache_dm_ro_if.slave    bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_hits,
    output logic [31:0]      perf_misses
`endif
);
    localparam int TAG_W = 28 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [127:0]       data_mem [LINES];
    logic               mem_read;
    logic [27:0]        mem_addr;

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [1:0]         word;
    logic [127:0]       line;
    logic               hit;
    logic               hit_ret;
    logic               miss_start;
    logic               refill;
    logic [INDEX_W-1:0] miss_index;
    logic               unused_bits;

    assign tag         = bus.proc_addr[29:INDEX_W+2];
    assign index       = bus.proc_addr[INDEX_W+1:2];
    assign word        = bus.proc_addr[1:0];
    assign line        = data_mem[index];
    assign hit         = valid[index] & (tag_mem[index] == tag);
    assign hit_ret     = (state == IDLE) & bus.proc_ren & hit;
    assign miss_start  = (state == IDLE) & bus.proc_ren & ~hit;
    assign refill      = (state == MISS) & bus.mem_ready;
    // the latched line address carries the miss index in its low bits
    assign miss_index  = mem_addr[INDEX_W-1:0];
    assign unused_bits = ^{bus.proc_wen, bus.proc_wdata};

    assign bus.proc_stall = bus.proc_ren & ((state == MISS) | ~hit);
    assign bus.proc_rdata = hit_ret ? line[{word, 5'b0} +: 32] : '0;
    assign bus.mem_read   = mem_read;
    assign bus.mem_addr   = mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= '0;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else if (miss_start) begin
            state    <= MISS;
            mem_read <= 1'b1;
            mem_addr <= bus.proc_addr[29:2];
        end else if (refill) begin
            state             <= IDLE;
            mem_read          <= 1'b0;
            valid[miss_index] <= 1'b1;
        end
    end

    // tag and data need no reset; a reset forces IDLE so no refill write can follow it
    always_ff @(posedge clk) begin
        if (refill) begin
            tag_mem[miss_index]  <= mem_addr[27:INDEX_W];
            data_mem[miss_index] <= bus.mem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            perf_hits   <= perf_hits + {31'd0, hit_ret};
            perf_misses <= perf_misses + {31'd0, miss_start};
        end
    end
`endif
endmodule

// File: tb/tb_icache_dm_ro.sv
// tb_icache_dm_ro: directed scoreboard bench for icache_dm_ro with INDEX_W = 3.
// The driver queues the expected response each cycle; a negedge monitor pops and compares.
module tb_icache_dm_ro;
    logic clk;
    logic rst_n;

    icache_dm_ro_if bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
    icache_dm_ro #(.INDEX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .perf_hits(perf_hits), .perf_misses(perf_misses)
    );
`else
    icache_dm_ro #(.INDEX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] rdata;
        logic        mr;
        logic [27:0] ma;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [127:0] LINE_A = {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [127:0] LINE_B = {32'h8, 32'h7, 32'h6, 32'h5};
    localparam logic [127:0] JUNK   = {4{32'hDEAD_BEEF}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.proc_stall !== e.stall || bus.proc_rdata !== e.rdata ||
                bus.mem_read !== e.mr || (e.mr && bus.mem_addr !== e.ma)) begin
                errors++;
                $display("FAIL %s: got stall=%b rdata=%h mem_read=%b mem_addr=%h, expected stall=%b rdata=%h mem_read=%b mem_addr=%h",
                         e.name, bus.proc_stall, bus.proc_rdata, bus.mem_read, bus.mem_addr,
                         e.stall, e.rdata, e.mr, e.ma);
            end
        end
    end

    task automatic step(input string name, input logic ren, input logic wen, input logic [29:0] addr,
                        input logic rdy, input logic [127:0] mdata,
                        input logic e_stall, input logic [31:0] e_rdata,
                        input logic e_mr, input logic [27:0] e_ma);
        exp_t e;
        bus.proc_ren   = ren;
        bus.proc_wen   = wen;
        bus.proc_addr  = addr;
        bus.proc_wdata = 32'hCAFE_F00D;
        bus.mem_ready  = rdy;
        bus.mem_rdata  = mdata;
        e.name  = name;
        e.stall = e_stall;
        e.rdata = e_rdata;
        e.mr    = e_mr;
        e.ma    = e_ma;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.proc_ren = 0; bus.proc_wen = 0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        @(posedge clk);
        #1;
        step("reset_stall",   1, 0, 30'h0,  0, '0,     1, 32'h0, 0, 28'h0);
        rst_n = 1'b1;
        // cold miss on address 0, refill, then hit
        step("miss0_req",     1, 0, 30'h0,  0, '0,     1, 32'h0, 0, 28'h0);
        step("miss0_wait",    1, 0, 30'h0,  0, '0,     1, 32'h0, 1, 28'h0);
        step("miss0_ready",   1, 0, 30'h0,  1, LINE_A, 1, 32'h0, 1, 28'h0);
        step("hit_a0",        1, 0, 30'h0,  0, JUNK,   0, 32'h1, 0, 28'h0);
        step("hit_a1",        1, 0, 30'h1,  0, '0,     0, 32'h2, 0, 28'h0);
        step("hit_a2",        1, 0, 30'h2,  0, '0,     0, 32'h3, 0, 28'h0);
        step("hit_a3",        1, 0, 30'h3,  0, '0,     0, 32'h4, 0, 28'h0);
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (perf_hits !== 32'd4 || perf_misses !== 32'd1) begin
            errors++;
            $display("FAIL perf: got hits=%0d misses=%0d, expected hits=4 misses=1", perf_hits, perf_misses);
        end
`endif
        // write-only cycle with a stray mem_ready in IDLE
        step("wen_idle",      0, 1, 30'h0,  1, JUNK,   0, 32'h0, 0, 28'h0);
        step("after_stray",   1, 0, 30'h0,  0, '0,     0, 32'h1, 0, 28'h0);
        // conflict miss at 0x20 maps to index 0
        step("conf_req",      1, 0, 30'h20, 0, '0,     1, 32'h0, 0, 28'h0);
        step("conf_ready",    1, 0, 30'h20, 1, LINE_B, 1, 32'h0, 1, 28'h8);
        step("conf_hit",      1, 0, 30'h20, 0, '0,     0, 32'h5, 0, 28'h0);
        step("reread0_miss",  1, 0, 30'h0,  0, '0,     1, 32'h0, 0, 28'h0);
        // requester moves away and drops ren during MISS
        step("drop_ren_1",    0, 0, 30'h4,  0, '0,     0, 32'h0, 1, 28'h0);
        step("drop_ren_2",    0, 0, 30'h4,  0, '0,     0, 32'h0, 1, 28'h0);
        step("drop_ren_3",    0, 0, 30'h4,  0, '0,     0, 32'h0, 1, 28'h0);
        step("drop_ren_4",    0, 0, 30'h4,  0, '0,     0, 32'h0, 1, 28'h0);
        step("drop_ren_rdy",  0, 0, 30'h4,  1, LINE_A, 0, 32'h0, 1, 28'h0);
        step("refill0_hit",   1, 0, 30'h2,  0, '0,     0, 32'h3, 0, 28'h0);
        step("idx1_miss",     1, 0, 30'h4,  0, '0,     1, 32'h0, 0, 28'h0);
        step("idx1_wait",     1, 0, 30'h4,  0, '0,     1, 32'h0, 1, 28'h1);
        // asynchronous reset mid-refill, applied between clock edges
        rst_n = 1'b0;
        step("rst_mid_miss",  1, 0, 30'h4,  1, LINE_B, 1, 32'h0, 0, 28'h0);
        rst_n = 1'b1;
        step("post_rst_miss", 1, 0, 30'h4,  0, '0,     1, 32'h0, 0, 28'h0);
        step("post_rst_wait", 1, 0, 30'h4,  0, '0,     1, 32'h0, 1, 28'h1);
        step("a0_lost",       0, 0, 30'h0,  0, '0,     0, 32'h0, 1, 28'h1);
        step("idx1_ready",    0, 0, 30'h0,  1, LINE_B, 0, 32'h0, 1, 28'h1);
        step("a0_miss_again", 1, 0, 30'h0,  0, '0,     1, 32'h0, 0, 28'h0);
        step("idx1_hit_miss", 1, 0, 30'h5,  0, '0,     1, 32'h0, 1, 28'h0);
        bus.proc_ren = 0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
